// File: rtl/lsu_align_unit.sv
// Load/store alignment engine between the memory stage and the data bus.
// Ports: req_* core request, mem_* bus beat + read return, rsp_* completion.
module lsu_align_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_misalign_err
);

  localparam int NB  = XLEN / 8;
  localparam int NB2 = 2 * NB;
  localparam int OW  = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    WAIT0,
    BEAT1,
    WAIT1,
    RESP
  } state_t;

  state_t            st;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   beat0_q;
  logic [XLEN-1:0]   beat1_q;
  logic              split_q;
  logic              err_q;

  function automatic logic f3_legal(
    input logic [2:0] f
  );
    f3_legal = (f != 3'b111) &&
               !(XLEN == 32 &&
                 (f == 3'b011 || f == 3'b110));
  endfunction

  function automatic logic is_split(
    input logic [OW-1:0] o,
    input logic [1:0]    s
  );
    logic [4:0] sum;
    sum = 5'(o) + (5'd1 << s);
    is_split = sum > 5'(NB);
  endfunction

  logic          req_split;
  logic          req_err;

  assign req_split = is_split(req_addr[OW-1:0],
                              req_funct3[1:0]);
  assign req_err = !f3_legal(req_funct3) ||
                   (req_split && !MISALIGN_EN);

  logic [OW-1:0]     off;
  logic [3:0]        sz;
  logic [6:0]        nbits;
  logic [ADDR_W-1:0] base0;
  logic [ADDR_W-1:0] base1;
  logic [NB2-1:0]    be_win;
  logic [2*XLEN-1:0] wd_win;
  logic [2*XLEN-1:0] ld_cat;
  logic [XLEN-1:0]   ld_win;
  logic [XLEN-1:0]   kmask;
  logic              sbit;
  logic [XLEN-1:0]   ld_res;

  assign off   = addr_q[OW-1:0];
  assign sz    = 4'd1 << f3_q[1:0];
  assign nbits = {sz, 3'b000};
  assign base0 = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
  // Second beat wraps modulo 2^ADDR_W.
  assign base1 = base0 + ADDR_W'(NB);

  assign be_win = ((NB2'(1) << sz) - NB2'(1)) << off;
  assign wd_win = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};

  assign ld_cat = split_q ? {beat1_q, beat0_q}
                          : {{XLEN{1'b0}}, beat0_q};
  assign ld_win = XLEN'(ld_cat >> {off, 3'b000});

  assign kmask = (nbits >= 7'(XLEN)) ? '1 :
                 ((XLEN'(1) << nbits) - XLEN'(1));
  // Top bit of the kept field is the sign bit.
  assign sbit = |(ld_win & kmask & ~(kmask >> 1));
  assign ld_res = (ld_win & kmask) |
                  ((!f3_q[2] && sbit) ? ~kmask : '0);

  assign req_ready = (st == IDLE);
  assign mem_valid = (st == BEAT0) || (st == BEAT1);
  assign mem_we    = mem_valid && we_q;
  assign rsp_valid = (st == RESP);
  assign rsp_misalign_err = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q)
                   ? ld_res : '0;

  always_comb begin
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (1'b1)
      (st == BEAT0): begin
        mem_addr  = base0;
        mem_be    = we_q ? be_win[NB-1:0] : '1;
        mem_wdata = we_q ? wd_win[XLEN-1:0] : '0;
      end
      (st == BEAT1): begin
        mem_addr  = base1;
        mem_be    = we_q ? be_win[NB2-1:NB] : '1;
        mem_wdata = we_q ? wd_win[2*XLEN-1:XLEN]
                         : '0;
      end
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat0_q <= '0;
      beat1_q <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            split_q <= req_split;
            err_q   <= req_err;
            st      <= req_err ? RESP : BEAT0;
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (!we_q)        st <= WAIT0;
            else if (split_q) st <= BEAT1;
            else              st <= RESP;
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            beat0_q <= mem_rdata;
            st      <= split_q ? BEAT1 : RESP;
          end
        end
        BEAT1: begin
          if (mem_ready) st <= we_q ? RESP : WAIT1;
        end
        WAIT1: begin
          if (mem_rvalid) begin
            beat1_q <= mem_rdata;
            st      <= RESP;
          end
        end
        RESP:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit (XLEN=32).
// u0: misaligned splitting on; u1: misaligned flagged.
module tb_lsu_align_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_valid1;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        req_ready, mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata, rsp_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_misalign_err;

  logic        req_ready1, mem_valid1, mem_we1;
  logic [31:0] mem_addr1, mem_wdata1, rsp_rdata1;
  logic [3:0]  mem_be1;
  logic        rsp_valid1, rsp_misalign_err1;

  int n_chk = 0;
  int n_fail = 0;

  lsu_align_unit #(
    .XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misalign_err(rsp_misalign_err)
  );

  lsu_align_unit #(
    .XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid1), .mem_ready(mem_ready),
    .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_be(mem_be1), .mem_wdata(mem_wdata1),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .rsp_misalign_err(rsp_misalign_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations from the last run_req.
  logic [31:0] ba[2];
  logic [3:0]  bbe[2];
  logic [31:0] bwd[2];
  logic        bwe[2];
  int          nb, nmv, nrsp, rsp_cyc, busy_rdy;
  logic [31:0] r_data;
  logic        r_err, hold_bad, acc_rdy;

  task automatic run_req(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] d0,
    input logic [31:0] d1,
    input int          stall
  );
    int   st_left;
    logic pend;
    logic seen;
    nb = 0; nmv = 0; nrsp = 0; rsp_cyc = -1;
    busy_rdy = 0; r_data = '0; r_err = 1'b0;
    hold_bad = 1'b0; seen = 1'b0; pend = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ba[i] = 'x; bbe[i] = 'x; bwd[i] = 'x; bwe[i] = 1'bx;
    end
    st_left = stall;
    @(negedge clk);
    acc_rdy = req_ready;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata = (nb == 1) ? d0 : d1;
        pend = 1'b0;
      end
      if (rsp_valid) begin
        nrsp++;
        if (rsp_cyc < 0) begin
          rsp_cyc = cyc; r_data = rsp_rdata;
          r_err = rsp_misalign_err;
        end
      end else if (rsp_cyc < 0 && req_ready) begin
        busy_rdy++;
      end
      if (mem_valid) begin
        nmv++;
        if (nb < 2) begin
          if (!seen) begin
            ba[nb] = mem_addr; bbe[nb] = mem_be;
            bwd[nb] = mem_wdata; bwe[nb] = mem_we;
            seen = 1'b1;
          end else if (mem_addr !== ba[nb] ||
                       mem_be !== bbe[nb] ||
                       mem_wdata !== bwd[nb]) begin
            hold_bad = 1'b1;
          end
        end
        if (st_left > 0) begin
          st_left--;
        end else begin
          mem_ready = 1'b1;
          if (!mem_we) pend = 1'b1;
          nb++; seen = 1'b0;
        end
      end
      if (rsp_cyc > 0 && cyc >= rsp_cyc + 2) break;
      @(negedge clk);
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    n_chk++;
    if ({req_ready, mem_valid, mem_we, rsp_valid,
         rsp_misalign_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 10000",
        {req_ready, mem_valid, mem_we, rsp_valid,
         rsp_misalign_err});
    end
    n_chk++;
    if ({mem_addr, mem_be, mem_wdata, rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h want 0",
        mem_addr, mem_be, mem_wdata, rsp_rdata);
    end
  endtask

  task automatic test_load_byte;
    run_req(1'b0, 3'b000, 32'h103, 0, 32'h80FF_FF12, 0, 0);
    n_chk++;
    if (acc_rdy !== 1'b1) begin
      n_fail++; $display("FAIL lb_accept: got %b want 1", acc_rdy);
    end
    n_chk++;
    if (ba[0] !== 32'h100 || bbe[0] !== 4'hF || nb !== 1) begin
      n_fail++;
      $display("FAIL lb_bus: got %h %h %0d want 100 f 1",
        ba[0], bbe[0], nb);
    end
    n_chk++;
    if (rsp_cyc !== 3 || nrsp !== 1 || busy_rdy !== 0) begin
      n_fail++;
      $display("FAIL lb_latency: got %0d/%0d/%0d want 3/1/0",
        rsp_cyc, nrsp, busy_rdy);
    end
    n_chk++;
    if (r_data !== 32'hFFFF_FF80 || r_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_data: got %h want ffffff80", r_data);
    end
    run_req(1'b0, 3'b100, 32'h103, 0, 32'h80FF_FF12, 0, 0);
    n_chk++;
    if (r_data !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL lbu_data: got %h want 00000080", r_data);
    end
    run_req(1'b0, 3'b000, 32'h101, 0, 32'h80FF_FF12, 0, 0);
    n_chk++;
    if (r_data !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL lb1_data: got %h want ffffffff", r_data);
    end
    run_req(1'b0, 3'b100, 32'h100, 0, 32'h80FF_FF12, 0, 0);
    n_chk++;
    if (r_data !== 32'h0000_0012) begin
      n_fail++;
      $display("FAIL lbu0_data: got %h want 00000012", r_data);
    end
  endtask

  task automatic test_load_half_word;
    run_req(1'b0, 3'b001, 32'h102, 0, 32'h80FF_FF12, 0, 0);
    n_chk++;
    if (r_data !== 32'hFFFF_80FF) begin
      n_fail++;
      $display("FAIL lh_data: got %h want ffff80ff", r_data);
    end
    run_req(1'b0, 3'b101, 32'h102, 0, 32'h80FF_FF12, 0, 0);
    n_chk++;
    if (r_data !== 32'h0000_80FF) begin
      n_fail++;
      $display("FAIL lhu_data: got %h want 000080ff", r_data);
    end
    run_req(1'b0, 3'b001, 32'h100, 0, 32'h80FF_FF12, 0, 0);
    n_chk++;
    if (r_data !== 32'hFFFF_FF12) begin
      n_fail++;
      $display("FAIL lh0_data: got %h want ffffff12", r_data);
    end
    run_req(1'b0, 3'b010, 32'h104, 0, 32'hDEAD_BEEF, 0, 0);
    n_chk++;
    if (r_data !== 32'hDEAD_BEEF || ba[0] !== 32'h104) begin
      n_fail++;
      $display("FAIL lw_data: got %h @%h want deadbeef @104",
        r_data, ba[0]);
    end
  endtask

  task automatic test_store;
    run_req(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 0, 0);
    n_chk++;
    if (ba[0] !== 32'h200 || bbe[0] !== 4'b1100 ||
        bwd[0][31:16] !== 16'hABCD || bwe[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_bus: got %h %b %h %b want 200 1100 abcd 1",
        ba[0], bbe[0], bwd[0][31:16], bwe[0]);
    end
    n_chk++;
    if (rsp_cyc !== 2 || nb !== 1 || r_data !== 32'h0) begin
      n_fail++;
      $display("FAIL sh_rsp: got %0d %0d %h want 2 1 0",
        rsp_cyc, nb, r_data);
    end
    run_req(1'b1, 3'b000, 32'h301, 32'h1234_5678, 0, 0, 0);
    n_chk++;
    if (bbe[0] !== 4'b0010 || bwd[0][15:8] !== 8'h78) begin
      n_fail++;
      $display("FAIL sb_bus: got %b %h want 0010 78",
        bbe[0], bwd[0][15:8]);
    end
    run_req(1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 0, 0, 0);
    n_chk++;
    if (bbe[0] !== 4'hF || bwd[0] !== 32'hCAFE_F00D ||
        ba[0] !== 32'h400) begin
      n_fail++;
      $display("FAIL sw_bus: got %h %h %h want f cafef00d 400",
        bbe[0], bwd[0], ba[0]);
    end
  endtask

  task automatic test_misaligned_load;
    run_req(1'b0, 3'b010, 32'h0FE, 0,
            32'h1122_3344, 32'h5566_7788, 0);
    n_chk++;
    if (nb !== 2 || ba[0] !== 32'h0FC || ba[1] !== 32'h100) begin
      n_fail++;
      $display("FAIL mlw_beats: got %0d %h %h want 2 fc 100",
        nb, ba[0], ba[1]);
    end
    n_chk++;
    if (r_data !== 32'h7788_1122 || rsp_cyc !== 5) begin
      n_fail++;
      $display("FAIL mlw_data: got %h @%0d want 77881122 @5",
        r_data, rsp_cyc);
    end
    run_req(1'b0, 3'b001, 32'h0FF, 0,
            32'hAABB_CCDD, 32'h1122_3385, 0);
    n_chk++;
    if (r_data !== 32'hFFFF_85AA || nb !== 2) begin
      n_fail++;
      $display("FAIL mlh_data: got %h/%0d want ffff85aa/2",
        r_data, nb);
    end
  endtask

  task automatic test_misaligned_store_wrap;
    run_req(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hA1B2_C3D4, 0, 0, 0);
    n_chk++;
    if (ba[0] !== 32'hFFFF_FFFC || ba[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL msw_addr: got %h %h want fffffffc 0",
        ba[0], ba[1]);
    end
    n_chk++;
    if (bbe[0] !== 4'b1000 || bbe[1] !== 4'b0111) begin
      n_fail++;
      $display("FAIL msw_be: got %b %b want 1000 0111",
        bbe[0], bbe[1]);
    end
    n_chk++;
    if (bwd[0][31:24] !== 8'hD4 ||
        bwd[1][23:0] !== 24'hA1B2C3 || rsp_cyc !== 3) begin
      n_fail++;
      $display("FAIL msw_data: got %h %h @%0d want d4 a1b2c3 @3",
        bwd[0][31:24], bwd[1][23:0], rsp_cyc);
    end
  endtask

  task automatic test_illegal_funct3;
    logic [2:0] f3s [3];
    f3s[0] = 3'b011; f3s[1] = 3'b110; f3s[2] = 3'b111;
    for (int i = 0; i < 3; i++) begin
      run_req(1'b0, f3s[i], 32'h100, 0, 32'hFFFF_FFFF, 0, 0);
      n_chk++;
      if (rsp_cyc !== 1 || r_err !== 1'b1 || nmv !== 0 ||
          r_data !== 32'h0) begin
        n_fail++;
        $display("FAIL illegal_f3_%b: got %0d %b %0d %h want 1 1 0 0",
          f3s[i], rsp_cyc, r_err, nmv, r_data);
      end
    end
  endtask

  task automatic test_misalign_disabled;
    logic [3:0] s1;
    logic [3:0] s2;
    @(negedge clk);
    s1[0] = req_ready1;
    req_valid1 = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0FE;
    @(negedge clk);
    req_valid1 = 1'b0;
    s1[1] = rsp_valid1; s1[2] = rsp_misalign_err1;
    s1[3] = mem_valid1;
    @(negedge clk);
    s2 = {rsp_valid1, mem_valid1, req_ready1, 1'b0};
    n_chk++;
    if (s1 !== 4'b0111 || rsp_rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL noalign_rsp: got %b want 0111", s1);
    end
    n_chk++;
    if (s2 !== 4'b0010) begin
      n_fail++;
      $display("FAIL noalign_after: got %b want 0010", s2);
    end
  endtask

  task automatic test_stall;
    run_req(1'b0, 3'b010, 32'h200, 0, 32'h0102_0304, 0, 2);
    n_chk++;
    if (hold_bad !== 1'b0 || nmv !== 3) begin
      n_fail++;
      $display("FAIL stall_hold: got %b/%0d want 0/3",
        hold_bad, nmv);
    end
    n_chk++;
    if (rsp_cyc !== 5 || r_data !== 32'h0102_0304) begin
      n_fail++;
      $display("FAIL stall_rsp: got %0d %h want 5 01020304",
        rsp_cyc, r_data);
    end
  endtask

  task automatic test_reset_abort;
    int seen_rsp;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    seen_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rsp_valid) seen_rsp++;
    end
    n_chk++;
    if (seen_rsp !== 0 || req_ready !== 1'b1 ||
        mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got rsp=%0d rdy=%b mv=%b want 0 1 0",
        seen_rsp, req_ready, mem_valid);
    end
  endtask

  task automatic test_back_to_back;
    run_req(1'b0, 3'b100, 32'h602, 0, 32'h00C3_0000, 0, 0);
    n_chk++;
    if (r_data !== 32'h0000_00C3 || rsp_cyc !== 3) begin
      n_fail++;
      $display("FAIL b2b_first: got %h @%0d want c3 @3",
        r_data, rsp_cyc);
    end
    run_req(1'b0, 3'b001, 32'h606, 0, 32'h9ABC_0000, 0, 0);
    n_chk++;
    if (r_data !== 32'hFFFF_9ABC || acc_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got %h rdy=%b want ffff9abc 1",
        r_data, acc_rdy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_valid1 = 1'b0; req_we = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_load_byte();
    test_load_half_word();
    test_store();
    test_misaligned_load();
    test_misaligned_store_wrap();
    test_illegal_funct3();
    test_misalign_disabled();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
